gc_label_collector: RTL

//  Sits directly downstream of GarbledCircuit and consumes its per-cycle label/key/table/mask stream
//  (tag_t1, cid, index*_t1, data*_t1). GarbledCircuit has no backpressure, so each non-idle beat is

---
 rtl/gc_collect_pkg.sv | 31 +++
 rtl/gc_sync_fifo.sv | 63 ++++++
 rtl/gc_label_collector.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/gc_collect_pkg.sv
// Shared types for the garbled-circuit label collector: record types, tag
// decode constants, the per-beat metadata carried through the FIFO.
package gc_collect_pkg;

   typedef enum logic [1:0] {REC_LABEL, REC_KEY, REC_TABLE, REC_MASK} rec_type_t;

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} ser_state_t;

   localparam int          FIELD_W       = 14;
   localparam int          TAG_LABEL_BIT = 2;
   localparam logic [1:0]  TAG_KEY       = 2'b01;
   localparam logic [1:0]  TAG_TABLE     = 2'b10;
   localparam logic [1:0]  TAG_MASK      = 2'b11;

   typedef struct packed {
      rec_type_t            typ;
      logic                 h0en;
      logic                 h1en;
      logic [FIELD_W-1:0]   cid;
      logic [FIELD_W-1:0]   idx0;
      logic [FIELD_W-1:0]   idx1;
   } beat_meta_t;

   // Header layout: type in the top two bits, 14-bit cid, 16-bit zero-extended index.
   function automatic logic [31:0] make_header(input rec_type_t t,
                                               input logic [FIELD_W-1:0] c,
                                               input logic [FIELD_W-1:0] idx);
      return {t, c, 2'b00, idx};
   endfunction

endpackage

// File: rtl/gc_sync_fifo.sv
// Synchronous FIFO with head and next-entry views; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module gc_sync_fifo #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int PEEK_W = WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [PEEK_W-1:0]          peek_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   assign rdata_o = mem[rd_ptr_q];
   assign peek_o  = mem[rd_ptr_q + AW'(1)][WIDTH-1 -: PEEK_W];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked solely by the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/gc_label_collector.sv
// Buffers non-idle GarbledCircuit beats and serializes them into header+data
// records on a registered valid/ready word stream; flags overflow and done.
module gc_label_collector
   import gc_collect_pkg::*;
#(
   parameter int S     = 10,
   parameter int K     = 128,
   parameter int W     = 32,
   parameter int DEPTH = 16,
   parameter int CC    = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    tag_t1,
   input  logic [S-1:0]  cid,
   input  logic [S-1:0]  index0_t1,
   input  logic [S-1:0]  index1_t1,
   input  logic [K-1:0]  data0_t1,
   input  logic [K-1:0]  data1_t1,
   output logic [W-1:0]  out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          overflow,
   output logic          done
);

   localparam int NW = K / W;
   localparam int CW = (NW > 1) ? $clog2(NW) : 1;
   localparam int MW = $bits(beat_meta_t);
   localparam int EW = MW + 2*K;
   localparam int AW = $clog2(DEPTH);

   if (S > FIELD_W) begin : g_bad_s
      $error("gc_label_collector: S must be <= 14");
   end
   if ((K % W) != 0) begin : g_bad_k
      $error("gc_label_collector: K must be a multiple of W");
   end

   beat_meta_t       in_meta, head_meta, peek_meta;
   logic             push_req, push_ok;
   logic [EW-1:0]    fifo_wdata, fifo_rdata;
   logic [MW-1:0]    fifo_peek;
   logic             fifo_full, fifo_empty, fifo_pop;
   logic [AW:0]      fifo_count, count_nxt;
   logic [K-1:0]     head_d0, head_d1;

   ser_state_t       state_q, state_d;
   logic             half_q, half_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             overflow_q, overflow_d;
   logic             cid_seen_q, cid_seen_d;
   logic             done_q, done_d;
   logic             accept;

   function automatic logic [W-1:0] data_word(input logic [K-1:0] d, input logic [CW-1:0] j);
      logic [K-1:0] sh;
      sh = d << (j * W);
      return sh[K-1 -: W];
   endfunction

   function automatic logic [W-1:0] hdr_word(input beat_meta_t m, input logic h1);
      return W'(make_header(m.typ, m.cid, h1 ? m.idx1 : m.idx0));
   endfunction

   always_comb begin
      in_meta      = '0;
      in_meta.typ  = REC_LABEL;
      in_meta.cid  = FIELD_W'(cid);
      in_meta.idx0 = FIELD_W'(index0_t1);
      in_meta.idx1 = FIELD_W'(index1_t1);
      if (tag_t1[TAG_LABEL_BIT]) begin
         in_meta.h0en = tag_t1[0];
         in_meta.h1en = tag_t1[1];
      end else begin
         case (tag_t1[1:0])
            TAG_KEY: begin
               in_meta.typ  = REC_KEY;
               in_meta.h0en = 1'b1;
               in_meta.h1en = 1'b1;
               in_meta.idx0 = FIELD_W'(0);
               in_meta.idx1 = FIELD_W'(1);
            end
            TAG_TABLE: begin
               in_meta.typ  = REC_TABLE;
               in_meta.h0en = 1'b1;
               in_meta.h1en = 1'b1;
            end
            TAG_MASK: begin
               in_meta.typ  = REC_MASK;
               in_meta.h0en = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign push_req   = in_meta.h0en | in_meta.h1en;
   assign fifo_wdata = {in_meta, data0_t1, data1_t1};

   gc_sync_fifo #(
      .WIDTH  (EW),
      .DEPTH  (DEPTH),
      .PEEK_W (MW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_req),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .peek_o  (fifo_peek),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign head_meta = beat_meta_t'(fifo_rdata[EW-1 -: MW]);
   assign head_d0   = fifo_rdata[2*K-1:K];
   assign head_d1   = fifo_rdata[K-1:0];
   assign peek_meta = beat_meta_t'(fifo_peek);
   assign accept    = out_valid_q & out_ready;

   // Next word is precomputed so out_data/out_valid come straight from flops.
   always_comb begin
      state_d     = state_q;
      half_d      = half_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      fifo_pop    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d     = ST_HDR;
               half_d      = ~head_meta.h0en;
               out_valid_d = 1'b1;
               out_data_d  = hdr_word(head_meta, ~head_meta.h0en);
            end
         end
         ST_HDR: begin
            if (accept) begin
               state_d    = ST_DATA;
               cnt_d      = '0;
               out_data_d = data_word(half_q ? head_d1 : head_d0, '0);
            end
         end
         ST_DATA: begin
            if (accept) begin
               if (cnt_q == CW'(NW-1)) begin
                  if (!half_q && head_meta.h1en) begin
                     state_d    = ST_HDR;
                     half_d     = 1'b1;
                     out_data_d = hdr_word(head_meta, 1'b1);
                  end else begin
                     fifo_pop = 1'b1;
                     if (fifo_count > (AW+1)'(1)) begin
                        state_d    = ST_HDR;
                        half_d     = ~peek_meta.h0en;
                        out_data_d = hdr_word(peek_meta, ~peek_meta.h0en);
                     end else begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                     end
                  end
               end else begin
                  cnt_d      = cnt_q + CW'(1);
                  out_data_d = data_word(half_q ? head_d1 : head_d0, cnt_q + CW'(1));
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
         end
      endcase
   end

   assign push_ok    = push_req & (~fifo_full | fifo_pop);
   assign count_nxt  = fifo_count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, fifo_pop};
   assign overflow_d = overflow_q | (push_req & fifo_full & ~fifo_pop);
   assign cid_seen_d = cid_seen_q | (cid == S'(CC));
   assign done_d     = done_q | (cid_seen_d & (count_nxt == '0) & (state_d == ST_IDLE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         half_q      <= 1'b0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         cid_seen_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         half_q      <= half_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
         cid_seen_q  <= cid_seen_d;
         done_q      <= done_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign overflow  = overflow_q;
   assign done      = done_q;

endmodule
